// File: rtl/clock_mode_control.sv
// clock_mode_control: switch-driven mode FSM for the clock (run, reset seconds, set minutes, set hours)
//   i_Clock                      system clock, rising edge
//   i_Reset_n                    asynchronous active-low reset, returns to IDLE
//   i_Switch                     mode switch level, already synchronous
//   o_Counters_Reset             clear request to the seconds counter
//   o_Counters_Enable_Increment  manual-increment enable for the counter being set
//   o_Counters_Enable_Count      count enables {hours, minutes, seconds}
//   o_Display_Enable_Digits      digit-group highlight {hours, minutes}
//   o_Display_Enable_Dot         seconds dot/colon enable
module clock_mode_control (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Switch,
  output logic       o_Counters_Reset,
  output logic       o_Counters_Enable_Increment,
  output logic [2:0] o_Counters_Enable_Count,
  output logic [1:0] o_Display_Enable_Digits,
  output logic       o_Display_Enable_Dot
);
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RESET_SEC = 2'b01,
    SET_MIN   = 2'b10,
    SET_HOUR  = 2'b11
  } state_e;
  state_e state_q, state_d;
  logic [7:0] dec;
  // Even states advance on a pressed switch, odd states on a released one;
  // the 2-bit increment wraps SET_HOUR back to IDLE.
  always_comb begin
    state_d = (i_Switch ^ state_q[0]) ? state_e'(state_q + 2'd1) : state_q;
  end
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end
  // Moore decode: {reset, increment, count[2:0], digits[1:0], dot}
  always_comb begin
    case (state_q)
      RESET_SEC: dec = 8'b1_0_000_00_0;
      SET_MIN:   dec = 8'b0_1_010_01_0;
      SET_HOUR:  dec = 8'b0_1_100_10_0;
      default:   dec = 8'b0_0_111_00_1;
    endcase
  end
  assign {o_Counters_Reset, o_Counters_Enable_Increment, o_Counters_Enable_Count,
          o_Display_Enable_Digits, o_Display_Enable_Dot} = dec;
endmodule

// File: tb/tb_clock_mode_control.sv
// tb_clock_mode_control: scoreboard bench for the clock mode-control FSM
module tb_clock_mode_control;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw = 1'b0;
  logic       c_rst, c_inc, d_dot;
  logic [2:0] c_en;
  logic [1:0] d_dig;
  localparam logic [7:0] E_IDLE = 8'b0_0_111_00_1;
  localparam logic [7:0] E_RS   = 8'b1_0_000_00_0;
  localparam logic [7:0] E_SM   = 8'b0_1_010_01_0;
  localparam logic [7:0] E_SH   = 8'b0_1_100_10_0;
  typedef struct {
    logic [7:0] exp;
    string      tag;
  } item_t;
  item_t q[$];
  int checks = 0;
  int errors = 0;
  event chk;
  clock_mode_control dut (
    .i_Clock                     (clk),
    .i_Reset_n                   (rst_n),
    .i_Switch                    (sw),
    .o_Counters_Reset            (c_rst),
    .o_Counters_Enable_Increment (c_inc),
    .o_Counters_Enable_Count     (c_en),
    .o_Display_Enable_Digits     (d_dig),
    .o_Display_Enable_Dot        (d_dot)
  );
  always #5 clk = ~clk;
  initial begin
    forever begin
      @(negedge clk or chk);
      while (q.size() > 0) begin
        item_t it;
        logic [7:0] got;
        it = q.pop_front();
        got = {c_rst, c_inc, c_en, d_dig, d_dot};
        checks++;
        if (got !== it.exp) begin
          errors++;
          $display("FAIL %s got %b expected %b at %0t", it.tag, got, it.exp, $time);
        end
      end
    end
  end
  task automatic step(input logic s, input logic [7:0] e, input string tag);
    sw = s;
    @(posedge clk);
    #1;
    q.push_back('{e, tag});
  endtask
  task automatic immediate(input logic [7:0] e, input string tag);
    q.push_back('{e, tag});
    ->chk;
    #1;
  endtask
  initial begin
    #2;
    immediate(E_IDLE, "reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step(1'b0, E_IDLE, "idle_after_reset");
    step(1'b1, E_RS,   "seq_reset_sec");
    step(1'b0, E_SM,   "seq_set_min");
    step(1'b1, E_SH,   "seq_set_hour");
    step(1'b0, E_IDLE, "seq_back_idle");
    repeat (12) step(1'b1, E_RS, "hold_reset_sec");
    step(1'b0, E_SM, "hold_release_min");
    repeat (20) step(1'b0, E_SM, "stable_set_min");
    step(1'b1, E_SH, "enter_set_hour");
    repeat (3) step(1'b1, E_SH, "stable_set_hour");
    step(1'b0, E_IDLE, "leave_set_hour");
    repeat (20) step(1'b0, E_IDLE, "stable_idle");
    step(1'b1, E_RS, "pulse_reset_sec");
    step(1'b0, E_SM, "pulse_set_min");
    step(1'b1, E_SH, "pulse_set_hour");
    step(1'b0, E_IDLE, "pulse_idle");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, E_RS,   "loop_reset_sec");
      step(1'b0, E_SM,   "loop_set_min");
      step(1'b1, E_SH,   "loop_set_hour");
      step(1'b0, E_IDLE, "loop_idle");
    end
    step(1'b1, E_RS, "mid_reset_sec");
    step(1'b0, E_SM, "mid_set_min");
    step(1'b1, E_SH, "mid_set_hour");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    immediate(E_IDLE, "async_reset_immediate");
    rst_n = 1'b1;
    step(1'b1, E_RS, "after_async_reset_sec");
    step(1'b0, E_SM, "after_async_set_min");
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
